// File: rtl/screen_flow_controller_pkg.sv
// Shared screen identifiers and timing constants for the screen sequencer.
package screen_flow_controller_pkg;

  typedef enum logic [1:0] {
    SCR_START = 2'd0,
    SCR_MAIN  = 2'd1,
    SCR_OVER  = 2'd2
  } SCREEN_ID;

  // 3 s of game-over display at 60 Hz
  localparam int unsigned FRAMES_GAME_OVER_DEFAULT = 180;

  function automatic logic [15:0] max_u16(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/screen_flow_controller_rise_edge_detect.sv
// Rising-edge detector; the history register reset value is configurable so a
// level already high at reset can be suppressed.
module rise_edge_detect #(
  parameter bit RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic resetN,
  input  logic in,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      prev_q <= RESET_VALUE;
    end else begin
      prev_q <= in;
    end
  end

  assign rise = in & ~prev_q;

endmodule

// File: rtl/screen_flow_controller.sv
// START -> MAIN -> GAME_OVER screen sequencer with new-game pulse, session high
// score and frame-aligned registered pixel selection.
module screen_flow_controller
  import screen_flow_controller_pkg::*;
#(
  parameter int unsigned FRAMES_GAME_OVER = FRAMES_GAME_OVER_DEFAULT
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        keyStartIsPressed,
  input  logic [3:0]  life,
  input  logic [15:0] score,
  input  logic [7:0]  RGB_screen_start,
  input  logic [7:0]  RGB_screen_main,
  input  logic [7:0]  RGB_screen_over,
  output logic [7:0]  RGB,
  output logic        start,
  output logic [1:0]  screenId,
  output logic [15:0] finalScore,
  output logic [15:0] highScore
);

  localparam logic [7:0] FramesLimit = 8'(FRAMES_GAME_OVER);

  SCREEN_ID    state_q, state_d;
  SCREEN_ID    screen_id_q;
  logic        start_q, start_d;
  logic        armed_q, armed_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [15:0] final_score_q, final_score_d;
  logic [15:0] high_score_q, high_score_d;
  logic [7:0]  rgb_q;
  logic        key_rise;

  rise_edge_detect #(
    .RESET_VALUE(1'b1)
  ) u_key_edge (
    .clk    (clk),
    .resetN (resetN),
    .in     (keyStartIsPressed),
    .rise   (key_rise)
  );

  always_comb begin
    state_d       = state_q;
    start_d       = 1'b0;
    armed_d       = armed_q;
    frame_cnt_d   = frame_cnt_q;
    final_score_d = final_score_q;
    high_score_d  = high_score_q;

    unique case (state_q)
      SCR_START: begin
        armed_d     = 1'b0;
        frame_cnt_d = 8'd0;
        if (key_rise) begin
          state_d = SCR_MAIN;
          start_d = 1'b1;
        end
      end
      SCR_MAIN: begin
        // Ignore a stale zero until the game screen has reloaded lives
        if (life != 4'd0) begin
          armed_d = 1'b1;
        end
        if (startOfFrame && armed_q && (life == 4'd0)) begin
          state_d       = SCR_OVER;
          final_score_d = score;
          high_score_d  = max_u16(high_score_q, score);
        end
      end
      SCR_OVER: begin
        if (startOfFrame && (frame_cnt_q < FramesLimit)) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
        if (key_rise && (frame_cnt_q >= FramesLimit)) begin
          state_d     = SCR_START;
          frame_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d = SCR_START;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q       <= SCR_START;
      start_q       <= 1'b0;
      armed_q       <= 1'b0;
      frame_cnt_q   <= 8'd0;
      final_score_q <= 16'd0;
      high_score_q  <= 16'd0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      armed_q       <= armed_d;
      frame_cnt_q   <= frame_cnt_d;
      final_score_q <= final_score_d;
      high_score_q  <= high_score_d;
    end
  end

  // The displayed screen only changes at a frame boundary
  always_ff @(posedge clk) begin
    if (!resetN) begin
      screen_id_q <= SCR_START;
      rgb_q       <= 8'h00;
    end else begin
      if (startOfFrame) begin
        screen_id_q <= state_q;
      end
      case (screen_id_q)
        SCR_START: rgb_q <= RGB_screen_start;
        SCR_MAIN:  rgb_q <= RGB_screen_main;
        SCR_OVER:  rgb_q <= RGB_screen_over;
        default:   rgb_q <= 8'h00;
      endcase
    end
  end

  assign RGB        = rgb_q;
  assign start      = start_q;
  assign screenId   = screen_id_q;
  assign finalScore = final_score_q;
  assign highScore  = high_score_q;

endmodule

// File: tb/tb_screen_flow_controller.sv
// Directed plus randomized bench for screen_flow_controller against a
// behavioural model of the screen flow.
module tb_screen_flow_controller;

  localparam int F = 4;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        keyStartIsPressed;
  logic [3:0]  life;
  logic [15:0] score;
  logic [7:0]  RGB_screen_start, RGB_screen_main, RGB_screen_over;
  logic [7:0]  RGB;
  logic        start;
  logic [1:0]  screenId;
  logic [15:0] finalScore, highScore;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: screens 0=start 1=main 2=over
  int          m_screen, m_shown, m_frames;
  bit          m_armed, m_key_prev, m_start;
  logic [15:0] m_final, m_high;
  logic [7:0]  m_rgb;

  screen_flow_controller #(
    .FRAMES_GAME_OVER(F)
  ) dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame      (startOfFrame),
    .keyStartIsPressed (keyStartIsPressed),
    .life              (life),
    .score             (score),
    .RGB_screen_start  (RGB_screen_start),
    .RGB_screen_main   (RGB_screen_main),
    .RGB_screen_over   (RGB_screen_over),
    .RGB               (RGB),
    .start             (start),
    .screenId          (screenId),
    .finalScore        (finalScore),
    .highScore         (highScore)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] colour_of(input int scr);
    if (scr == 0) return RGB_screen_start;
    if (scr == 1) return RGB_screen_main;
    if (scr == 2) return RGB_screen_over;
    return 8'h00;
  endfunction

  // One clock: inputs already set by caller; model predicts the post-edge outputs.
  task automatic step(input logic rst_v, input logic sof_v);
    int          n_screen, n_shown, n_frames;
    bit          n_armed, n_start, pressed;
    logic [15:0] n_final, n_high;
    logic [7:0]  n_rgb;
    @(negedge clk);
    resetN       = rst_v;
    startOfFrame = sof_v;
    pressed  = keyStartIsPressed && !m_key_prev;
    n_screen = m_screen;
    n_shown  = m_shown;
    n_frames = m_frames;
    n_armed  = m_armed;
    n_final  = m_final;
    n_high   = m_high;
    n_start  = 1'b0;
    n_rgb    = colour_of(m_shown);
    if (!rst_v) begin
      n_screen = 0; n_shown = 0; n_frames = 0; n_armed = 0;
      n_final = 0; n_high = 0; n_rgb = 0;
      m_key_prev = 1'b1;
    end else begin
      m_key_prev = keyStartIsPressed;
      if (sof_v) n_shown = m_screen;
      if (m_screen == 0) begin
        n_frames = 0;
        n_armed  = 0;
        if (pressed) begin
          n_screen = 1;
          n_start  = 1'b1;
        end
      end else if (m_screen == 1) begin
        if (life != 0) n_armed = 1;
        if (sof_v && m_armed && life == 0) begin
          n_screen = 2;
          n_final  = score;
          n_high   = (score > m_high) ? score : m_high;
        end
      end else begin
        if (sof_v) n_frames = (m_frames + 1 > F) ? F : m_frames + 1;
        if (pressed && m_frames == F) begin
          n_screen = 0;
          n_frames = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    m_screen = n_screen; m_shown = n_shown; m_frames = n_frames; m_armed = n_armed;
    m_final = n_final; m_high = n_high; m_start = n_start; m_rgb = n_rgb;
    chk("start", 16'(start), 16'(m_start));
    chk("screenId", 16'(screenId), 16'(m_shown));
    chk("RGB", 16'(RGB), 16'(m_rgb));
    chk("finalScore", finalScore, m_final);
    chk("highScore", highScore, m_high);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic frame();
    step(1'b1, 1'b1);
  endtask

  task automatic press();
    keyStartIsPressed = 1'b0;
    step(1'b1, 1'b0);
    keyStartIsPressed = 1'b1;
    step(1'b1, 1'b0);
  endtask

  // Play a full game from the start screen and end it at score sc.
  task automatic play_game(input logic [15:0] sc);
    press();
    chk("start_pulse", 16'(start), 16'd1);
    idle(1);
    life = 4'd3; score = sc;
    idle(2);
    frame();
    life = 4'd0;
    frame();
    chk("final_latched", finalScore, sc);
    idle(1);
  endtask

  task automatic leave_over();
    for (int i = 0; i < F; i++) begin
      frame();
      idle(1);
    end
    press();
    frame();
    chk("back_to_start", 16'(screenId), 16'd0);
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; keyStartIsPressed = 1'b1;
    life = 4'd0; score = 16'd0;
    RGB_screen_start = 8'h11; RGB_screen_main = 8'h22; RGB_screen_over = 8'h33;
    m_screen = 0; m_shown = 0; m_frames = 0; m_armed = 0; m_key_prev = 1;
    m_start = 0; m_final = 0; m_high = 0; m_rgb = 0;

    // Reset with key held: no pulse at release or while still held
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("reset_rgb", 16'(RGB), 16'h0);
    idle(3);
    chk("no_pulse_held", 16'(start), 16'd0);
    press();
    chk("first_pulse", 16'(start), 16'd1);
    idle(1);
    chk("pulse_once", 16'(start), 16'd0);
    frame();

    // Stale zero lives before arming must not end the game
    life = 4'd0;
    frame(); frame();
    life = 4'd3; score = 16'h0123;
    idle(2);
    frame();
    chk("main_shown", 16'(screenId), 16'd1);
    life = 4'd0;
    frame();  // transition coincides with frame: display keeps main
    chk("final_0123", finalScore, 16'h0123);
    chk("high_0123", highScore, 16'h0123);
    chk("shown_old", 16'(screenId), 16'd1);
    idle(1);
    chk("rgb_main", 16'(RGB), 16'h22);
    frame();
    chk("shown_over", 16'(screenId), 16'd2);
    idle(1);
    chk("rgb_over", 16'(RGB), 16'h33);

    // Lockout: the first frame above already counted one of F
    frame(); frame();
    press();
    frame();
    chk("locked_out", 16'(screenId), 16'd2);
    press();
    frame();
    chk("unlocked", 16'(screenId), 16'd0);
    idle(1);
    chk("rgb_start", 16'(RGB), 16'h11);

    play_game(16'h0050);
    chk("high_kept", highScore, 16'h0123);
    leave_over();
    play_game(16'h0200);
    chk("high_new", highScore, 16'h0200);
    leave_over();

    // Reset mid-game
    press();
    life = 4'd2;
    idle(2);
    frame();
    step(1'b0, 1'b0);
    chk("rst_high", highScore, 16'h0);
    chk("rst_rgb", 16'(RGB), 16'h0);
    chk("rst_start", 16'(start), 16'd0);
    idle(2);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) keyStartIsPressed = ~keyStartIsPressed;
      life  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
      score = 16'($urandom);
      RGB_screen_start = 8'($urandom);
      RGB_screen_main  = 8'($urandom);
      RGB_screen_over  = 8'($urandom);
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 5) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
